sine_sweep_ctrl: RTL and testbench

SINE_SWEEP_CTRL -- requirements
Module: sine_sweep_ctrl

---
 rtl/sine_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_sine_sweep_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sine_sweep_ctrl.sv
// sine_sweep_ctrl: frequency-sweep sequencer driving a sine generator's en/incr/phase inputs
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, stop               sweep request (IDLE only), abort request (sweep states only)
//   cfg_incr_start/_end/_step first/last tone increment and per-step change
//   cfg_dwell                 cycles per tone (0 treated as 1)
//   cfg_phase                 phase offset passed to the generator
//   cfg_bidir, cfg_loop       add a down leg / repeat until stop
//   en, incr, phase           registered sine generator controls
//   busy, done                high while sweeping / one-cycle end-of-sweep pulse
module sine_sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   cfg_incr_start,
    input  logic [WIDTH-1:0]   cfg_incr_end,
    input  logic [WIDTH-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [WIDTH-1:0]   cfg_phase,
    input  logic               cfg_bidir,
    input  logic               cfg_loop,
    output logic               en,
    output logic [WIDTH-1:0]   incr,
    output logic [WIDTH-1:0]   phase,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, SWEEP_UP, SWEEP_DOWN, DONE} state_t;
    state_t state, state_n;
    logic [DWELL_W-1:0] cnt, cnt_n, s_dwell;
    logic [WIDTH-1:0] s_start, s_end, s_step, incr_n, phase_n, up_next, dn_next;
    logic s_bidir, s_loop, en_n, busy_n, done_n, term, single, fin;
    logic [WIDTH:0] up_sum;
    logic signed [WIDTH:0] dn_diff;
    // Saturating neighbours of the current tone, computed one bit wider so nothing wraps
    assign up_sum  = {1'b0, incr} + {1'b0, s_step};
    assign up_next = (up_sum >= {1'b0, s_end}) ? s_end : up_sum[WIDTH-1:0];
    assign dn_diff = $signed({1'b0, incr}) - $signed({1'b0, s_step});
    assign dn_next = (dn_diff <= $signed({1'b0, s_start})) ? s_start : dn_diff[WIDTH-1:0];
    assign term    = cnt == s_dwell - DWELL_W'(1);
    // A degenerate range plays one tone and finishes regardless of bidir/loop
    assign single  = s_start >= s_end;
    always_comb begin
        state_n = state;
        en_n    = en;
        incr_n  = incr;
        phase_n = phase;
        busy_n  = busy;
        done_n  = 1'b0;
        cnt_n   = cnt;
        fin     = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = SWEEP_UP;
                en_n    = 1'b1;
                busy_n  = 1'b1;
                incr_n  = cfg_incr_start;
                phase_n = cfg_phase;
                cnt_n   = '0;
            end
            SWEEP_UP, SWEEP_DOWN: begin
                if (stop) fin = 1'b1;
                else if (!term) cnt_n = cnt + DWELL_W'(1);
                else begin
                    cnt_n = '0;
                    if (state == SWEEP_UP) begin
                        if (!single && incr != s_end) incr_n = up_next;
                        else if (!single && s_bidir) begin
                            state_n = SWEEP_DOWN;
                            incr_n  = dn_next;
                        end
                        else if (!single && s_loop) incr_n = s_start;
                        else fin = 1'b1;
                    end
                    else begin
                        if (incr != s_start) incr_n = dn_next;
                        else if (s_loop) begin
                            state_n = SWEEP_UP;
                            incr_n  = up_next;
                        end
                        else fin = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (fin) begin
            state_n = DONE;
            en_n    = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            cnt_n   = '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            en    <= 1'b0;
            incr  <= '0;
            phase <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end
        else begin
            state <= state_n;
            en    <= en_n;
            incr  <= incr_n;
            phase <= phase_n;
            busy  <= busy_n;
            done  <= done_n;
            cnt   <= cnt_n;
        end
    end
    // Shadow configuration, normalised so zero dwell/step behave as one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_start <= '0;
            s_end   <= '0;
            s_step  <= '0;
            s_dwell <= '0;
            s_bidir <= 1'b0;
            s_loop  <= 1'b0;
        end
        else if (state == IDLE && start) begin
            s_start <= cfg_incr_start;
            s_end   <= cfg_incr_end;
            s_step  <= (cfg_step == '0) ? WIDTH'(1) : cfg_step;
            s_dwell <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
            s_bidir <= cfg_bidir;
            s_loop  <= cfg_loop;
        end
    end
endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// tb_sine_sweep_ctrl: directed scoreboard bench for sine_sweep_ctrl
module tb_sine_sweep_ctrl;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0;
    logic [7:0] cfg_incr_start = '0, cfg_incr_end = '0, cfg_step = '0, cfg_phase = '0;
    logic [15:0] cfg_dwell = '0;
    logic cfg_bidir = 1'b0, cfg_loop = 1'b0;
    logic en, busy, done;
    logic [7:0] incr, phase;

    typedef struct packed {
        logic en;
        logic [7:0] incr;
        logic [7:0] phase;
        logic busy;
        logic done;
    } obs_t;

    obs_t q[$];
    int n_chk = 0, n_fail = 0;
    logic [7:0] cur_ph = '0;

    sine_sweep_ctrl #(.WIDTH(8), .DWELL_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_incr_start(cfg_incr_start), .cfg_incr_end(cfg_incr_end),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_phase(cfg_phase),
        .cfg_bidir(cfg_bidir), .cfg_loop(cfg_loop),
        .en(en), .incr(incr), .phase(phase), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic push_n(input int n, input logic e, input logic [7:0] i, input logic b, input logic d);
        repeat (n) q.push_back(obs_t'{e, i, cur_ph, b, d});
    endtask

    task automatic chk(input string tag, input obs_t exp);
        obs_t got;
        got = obs_t'{en, incr, phase, busy, done};
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got en=%0b incr=%0d phase=%0d busy=%0b done=%0b, expected en=%0b incr=%0d phase=%0d busy=%0b done=%0b",
                   tag, got.en, got.incr, got.phase, got.busy, got.done,
                   exp.en, exp.incr, exp.phase, exp.busy, exp.done);
        end
    endtask

    task automatic drain_n(input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            if (q.size() > 0) chk(tag, q.pop_front());
        end
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) begin
            @(negedge clk);
            chk(tag, q.pop_front());
        end
    endtask

    task automatic set_cfg(input logic [7:0] s, input logic [7:0] e, input logic [7:0] st,
                           input logic [15:0] dw, input logic [7:0] ph, input logic bi, input logic lp);
        cfg_incr_start = s;
        cfg_incr_end   = e;
        cfg_step       = st;
        cfg_dwell      = dw;
        cfg_phase      = ph;
        cfg_bidir      = bi;
        cfg_loop       = lp;
        cur_ph         = ph;
    endtask

    task automatic go(input logic with_stop);
        start = 1'b1;
        stop  = with_stop;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk("reset", obs_t'('0));
        @(negedge clk) rst = 1'b0;

        // Basic up sweep; cfg inputs scrambled while busy must not matter
        set_cfg(8'd10, 8'd40, 8'd10, 16'd3, 8'd77, 1'b0, 1'b0);
        go(1'b0);
        set_cfg(8'd99, 8'd1, 8'd3, 16'd9, 8'd1, 1'b1, 1'b1);
        cur_ph = 8'd77;
        push_n(3, 1'b1, 8'd10, 1'b1, 1'b0);
        push_n(3, 1'b1, 8'd20, 1'b1, 1'b0);
        push_n(3, 1'b1, 8'd30, 1'b1, 1'b0);
        push_n(3, 1'b1, 8'd40, 1'b1, 1'b0);
        push_n(1, 1'b0, 8'd40, 1'b0, 1'b1);
        drain("up_sweep");

        // Start issued in the DONE cycle lands in the following IDLE cycle; top end saturates
        set_cfg(8'd250, 8'd255, 8'd10, 16'd1, 8'd5, 1'b0, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cur_ph = 8'd77;
        push_n(1, 1'b0, 8'd40, 1'b0, 1'b0);
        drain("idle_after_done");
        go(1'b0);
        cur_ph = 8'd5;
        push_n(1, 1'b1, 8'd250, 1'b1, 1'b0);
        push_n(1, 1'b1, 8'd255, 1'b1, 1'b0);
        push_n(1, 1'b0, 8'd255, 1'b0, 1'b1);
        push_n(1, 1'b0, 8'd255, 1'b0, 1'b0);
        drain("no_wrap");

        // Bidirectional sweep, started with stop also high in IDLE
        set_cfg(8'd0, 8'd20, 8'd10, 16'd1, 8'd9, 1'b1, 1'b0);
        go(1'b1);
        push_n(1, 1'b1, 8'd0, 1'b1, 1'b0);
        push_n(1, 1'b1, 8'd10, 1'b1, 1'b0);
        push_n(1, 1'b1, 8'd20, 1'b1, 1'b0);
        push_n(1, 1'b1, 8'd10, 1'b1, 1'b0);
        push_n(1, 1'b1, 8'd0, 1'b1, 1'b0);
        push_n(1, 1'b0, 8'd0, 1'b0, 1'b1);
        push_n(1, 1'b0, 8'd0, 1'b0, 1'b0);
        drain("bidir");

        // Looping sweep aborted on the terminal dwell cycle of the second 5
        set_cfg(8'd0, 8'd10, 8'd5, 16'd2, 8'd33, 1'b0, 1'b1);
        go(1'b0);
        push_n(2, 1'b1, 8'd0, 1'b1, 1'b0);
        push_n(2, 1'b1, 8'd5, 1'b1, 1'b0);
        push_n(2, 1'b1, 8'd10, 1'b1, 1'b0);
        push_n(2, 1'b1, 8'd0, 1'b1, 1'b0);
        push_n(2, 1'b1, 8'd5, 1'b1, 1'b0);
        drain("loop");
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        push_n(1, 1'b0, 8'd5, 1'b0, 1'b1);
        push_n(1, 1'b0, 8'd5, 1'b0, 1'b0);
        drain("stop_abort");

        // Zero dwell/step, start==end: one tone only; start while busy is ignored
        set_cfg(8'd255, 8'd255, 8'd0, 16'd0, 8'd200, 1'b1, 1'b1);
        go(1'b0);
        start = 1'b1;
        push_n(1, 1'b1, 8'd255, 1'b1, 1'b0);
        push_n(1, 1'b0, 8'd255, 1'b0, 1'b1);
        push_n(2, 1'b0, 8'd255, 1'b0, 1'b0);
        drain_n("single_tone", 1);
        @(posedge clk);
        #1 start = 1'b0;
        drain("single_tone");

        // Asynchronous reset mid-sweep, then start on the first edge after release
        set_cfg(8'd10, 8'd40, 8'd10, 16'd3, 8'd66, 1'b0, 1'b0);
        go(1'b0);
        push_n(3, 1'b1, 8'd10, 1'b1, 1'b0);
        push_n(1, 1'b1, 8'd20, 1'b1, 1'b0);
        drain("pre_reset");
        #2 rst = 1'b1;
        #1 chk("async_reset", obs_t'('0));
        @(negedge clk);
        chk("reset_no_done", obs_t'('0));
        rst = 1'b0;
        go(1'b0);
        push_n(1, 1'b1, 8'd10, 1'b1, 1'b0);
        drain("start_after_reset");
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        push_n(1, 1'b0, 8'd10, 1'b0, 1'b1);
        push_n(1, 1'b0, 8'd10, 1'b0, 1'b0);
        drain("final_stop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
